uart_image_loader: RTL
======================

UART_IMAGE_LOADER -- requirements
Module: uart_image_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rx  input  1  UART serial line, 8N1, LSB first, idle high; asynchronous to clk.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a load; sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  32  first data-memory byte address; captured on accepted start.
REQ-007 SHALL have port length  input  32  number of bytes to load; captured on accepted start.
REQ-008 SHALL have port wr_enable  output  1  data-memory write strobe, one cycle per byte.
REQ-009 SHALL have port mem_addr  output  32  data-memory write address.
REQ-010 SHALL have port mem_data  output  32  data-memory write data, {24'b0, received byte}.
REQ-011 SHALL have port busy  output  1  high from accepted start until done.
REQ-012 SHALL have port done  output  1  one-cycle pulse when load completes.
REQ-013 SHALL have port frame_err  output  1  sticky flag: at least one stop-bit error in current load.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer preset to 1; all decoding uses the synchronized value.
REQ-015 SHALL implement FSM states IDLE, WAIT_START, START_BIT, DATA_BITS, STOP_BIT, WRITE, FINISH.
REQ-016 IDLE: start=1 SHALL capture base_addr/length, clear count and frame_err, raise busy, go WAIT_START (or FINISH if length=0).
REQ-017 WAIT_START: synchronized rx=0 SHALL load bit timer and go START_BIT.
REQ-018 START_BIT: after CLKS_PER_BIT/2 cycles, rx=0 SHALL go DATA_BITS; rx=1 SHALL treat as glitch and return to WAIT_START with no side effects.
REQ-019 DATA_BITS: SHALL sample rx every CLKS_PER_BIT cycles (mid-bit), shifting LSB first, 8 samples, then go STOP_BIT.
REQ-020 STOP_BIT: after CLKS_PER_BIT cycles, rx=1 SHALL go WRITE; rx=0 SHALL set frame_err, discard byte, not advance count, go WAIT_START.
REQ-021 WRITE: SHALL assert wr_enable for exactly one cycle with mem_addr=base+count (32-bit, wraps modulo 2^32) and mem_data={24'b0,byte}, then increment count.
REQ-022 After WRITE, count=length SHALL go FINISH, else WAIT_START.
REQ-023 FINISH: SHALL pulse done for one cycle, drop busy in the same cycle, go IDLE.
REQ-024 start while not IDLE SHALL be ignored; base_addr/length changes after capture SHALL have no effect.
REQ-025 wr_enable SHALL never assert outside WRITE; mem_addr/mem_data SHALL hold last written values otherwise.
REQ-026 frame_err SHALL remain set through done and IDLE until the next accepted start.
REQ-027 Bytes arriving while IDLE SHALL be ignored entirely (no write, no error).
REQ-028 Bit timer and count SHALL be sized to CLKS_PER_BIT and 32 bits respectively; no truncation.

Reset
REQ-029 reset SHALL force state IDLE, rx synchronizer to 1, wr_enable=0, mem_addr=0, mem_data=0, busy=0, done=0, frame_err=0, count=0, immediately and asynchronously.
REQ-030 reset mid-byte or mid-load SHALL abort with no further writes; a partially received byte SHALL never be written.
REQ-031 First start after reset release SHALL behave identically to a start after power-up.

Verification (CLKS_PER_BIT=4)
REQ-032 start, base=0x100, length=3; send 0xA5,0x3C,0xFF -> three wr_enable pulses, addr 0x100/0x101/0x102, data 0xA5/0x3C/0xFF; done one cycle after third write; busy low after.
REQ-033 start, length=0 -> done pulse within 2 cycles, zero wr_enable, frame_err=0.
REQ-034 length=2; first byte 0x55 with stop bit 0, then 0x11, 0x22 -> frame_err=1, writes 0x11@base, 0x22@base+1 only, frame_err still 1 after done.
REQ-035 rx low pulse of 1 cycle in WAIT_START -> no write, no error, next valid byte 0x7E written at base.
REQ-036 reset asserted during DATA_BITS of second byte -> all outputs 0 within same cycle, no second write; new start with base=0x200 writes next byte at 0x200.
REQ-037 base=0xFFFFFFFF, length=2 -> writes at 0xFFFFFFFF then 0x00000000.

Source files
------------

// File: rtl/uart_image_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_image_loader
//  Description : Receives 8N1 UART bytes and writes each one, zero-extended,
//                to consecutive data-memory byte addresses starting at a
//                captured base address, for a captured byte count.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_image_loader #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [31:0] length,
  output logic        wr_enable,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        busy,
  output logic        done,
  output logic        frame_err
);

  // Timer wide enough to hold CLKS_PER_BIT-1 without truncation.
  localparam int TMR_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TMR_W-1:0] c_tmr_full = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] c_tmr_half = TMR_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_START = 3'd1,
    S_START_BIT  = 3'd2,
    S_DATA_BITS  = 3'd3,
    S_STOP_BIT   = 3'd4,
    S_WRITE      = 3'd5,
    S_FINISH     = 3'd6
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_rx_meta;
  logic               r_rx_sync;
  logic [TMR_W-1:0]   r_timer;
  logic [2:0]         r_bitcnt;
  logic [7:0]         r_shift;
  logic [31:0]        r_count;
  logic [31:0]        r_base;
  logic [31:0]        r_len;
  logic               r_frame_err;
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_mem_data;

  logic               w_tmr_zero;
  logic [31:0]        w_count_p1;
  logic               w_accept;
  logic               w_tmr_half;
  logic               w_tmr_full;
  logic               w_sample;
  logic               w_frame_set;
  logic               w_load_out;
  logic               w_count_inc;

  assign w_tmr_zero = (r_timer == '0);
  assign w_count_p1 = r_count + 32'd1;
  assign mem_addr   = r_mem_addr;
  assign mem_data   = r_mem_data;
  assign frame_err  = r_frame_err;

  // Two-flop synchronizer for the asynchronous serial line, idling high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode, datapath control strobes and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_tmr_half  = 1'b0;
    w_tmr_full  = 1'b0;
    w_sample    = 1'b0;
    w_frame_set = 1'b0;
    w_load_out  = 1'b0;
    w_count_inc = 1'b0;
    wr_enable   = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = (length == 32'd0) ? S_FINISH : S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        if (!r_rx_sync) begin
          w_tmr_half  = 1'b1;
          w_state_nxt = S_START_BIT;
        end
      end
      S_START_BIT: begin
        // Re-check the line at mid start bit; a high line was only a glitch.
        if (w_tmr_zero) begin
          if (!r_rx_sync) begin
            w_tmr_full  = 1'b1;
            w_state_nxt = S_DATA_BITS;
          end else begin
            w_state_nxt = S_WAIT_START;
          end
        end
      end
      S_DATA_BITS: begin
        if (w_tmr_zero) begin
          w_sample   = 1'b1;
          w_tmr_full = 1'b1;
          if (r_bitcnt == 3'd7) w_state_nxt = S_STOP_BIT;
        end
      end
      S_STOP_BIT: begin
        if (w_tmr_zero) begin
          if (r_rx_sync) begin
            w_load_out  = 1'b1;
            w_state_nxt = S_WRITE;
          end else begin
            w_frame_set = 1'b1;
            w_state_nxt = S_WAIT_START;
          end
        end
      end
      S_WRITE: begin
        wr_enable   = 1'b1;
        w_count_inc = 1'b1;
        w_state_nxt = (w_count_p1 == r_len) ? S_FINISH : S_WAIT_START;
      end
      S_FINISH: begin
        done        = 1'b1;
        busy        = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: bit timer, shift register, load bookkeeping and write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer     <= '0;
      r_bitcnt    <= 3'd0;
      r_shift     <= 8'd0;
      r_count     <= 32'd0;
      r_base      <= 32'd0;
      r_len       <= 32'd0;
      r_frame_err <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_data  <= 32'd0;
    end else begin
      if (w_tmr_half)       r_timer <= c_tmr_half;
      else if (w_tmr_full)  r_timer <= c_tmr_full;
      else if (!w_tmr_zero) r_timer <= r_timer - TMR_W'(1);

      if (w_tmr_half) r_bitcnt <= 3'd0;
      else if (w_sample) r_bitcnt <= r_bitcnt + 3'd1;

      // LSB arrives first, so shift in from the top.
      if (w_sample) r_shift <= {r_rx_sync, r_shift[7:1]};

      if (w_accept) begin
        r_base      <= base_addr;
        r_len       <= length;
        r_count     <= 32'd0;
        r_frame_err <= 1'b0;
      end else begin
        if (w_count_inc) r_count <= w_count_p1;
        if (w_frame_set) r_frame_err <= 1'b1;
      end

      // Address/data are loaded on entry to WRITE and then held.
      if (w_load_out) begin
        r_mem_addr <= r_base + r_count;
        r_mem_data <= {24'd0, r_shift};
      end
    end
  end

endmodule
`default_nettype wire
